tlb_lookup_arbiter: RTL and testbench
=====================================

Name: tlb_lookup_arbiter

Overview:
Shares the single 8-entry TLB array between two requesters: instruction fetch (F) and memory stage (M). Arbitrates one lookup per cycle using fixed M priority plus a fetch anti-starvation counter. Registers the translation result, returning a one-cycle response pulse with the PFN and page-fault indication to the granted requester. Sits between the TLB storage and the fetch/mem pipeline stages, replacing per-stage combinational TLB compare logic.

Parameters:
STARVE_LIMIT, 3, consecutive cycles F may be denied while requesting before F is forced to win the next arbitration.
CNT_W, 2, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
TLB  input  352  8 entries x 44 bits; entry i at [44*i+43:44*i]; [43:24] VPN, [6:4] PFN, [3] valid, [2] present, [1] writable
f_req  input  1  fetch lookup request; held until f_gnt
f_vaddr  input  32  fetch virtual address; stable while f_req is high
f_gnt  output  1  combinational grant to fetch, this cycle
f_rsp_vld  output  1  registered fetch response valid pulse
f_PFN  output  3  fetch physical frame number
f_page_fault  output  1  fetch translation fault
m_req  input  1  memory-stage lookup request; held until m_gnt
m_vaddr  input  32  memory virtual address
m_wr  input  1  memory access is a write
m_gnt  output  1  combinational grant to memory stage
m_rsp_vld  output  1  registered memory response valid pulse
m_PFN  output  3  memory physical frame number
m_page_fault  output  1  memory translation fault

Behaviour:
- Reset (rst_n low, asynchronous): f_rsp_vld=0, m_rsp_vld=0, f_PFN=0, m_PFN=0, f_page_fault=0, m_page_fault=0, starvation counter=0. Grants are 0 while rst_n is low. An in-flight lookup is dropped, and no response is produced after reset releases.
- Arbitration (combinational, each cycle):
  - Only one request: that requester is granted.
  - Both requesting: M wins, unless starve_cnt == STARVE_LIMIT, in which case F wins.
  - At most one grant per cycle. f_gnt and m_gnt are never both 1.
- Starvation counter:
  - Increments when f_req=1 and f_gnt=0, saturating at STARVE_LIMIT.
  - Clears when f_gnt=1 or when f_req=0.
- Lookup: performed on the granted address in the grant cycle.
  - Entry i hits when VPN == vaddr[31:12], valid == 1 and present == 1.
  - Exactly one hit: PFN = that entry's PFN.
  - Zero hits or multiple hits: PFN = 0.
- Fault rules:
  - Fault when no entry hits.
  - For M only, a fault is also raised on a hit to an entry with writable=0 while m_wr=1.
  - A multi-hit is not a fault.
- Latency and throughput:
  - Response is registered: the grant in cycle N produces rsp_vld=1 in cycle N+1 only, with PFN and fault valid that cycle.
  - Back-to-back grants are allowed, giving full throughput of 1 lookup/cycle.
- Response outputs:
  - PFN and fault outputs hold their last value when rsp_vld=0.
  - Only the granted side's output registers update.
- TLB contents changing in the grant cycle: the lookup uses the value present in that cycle. No snapshot is taken.
- Requesters must keep req and address stable until gnt. Dropping req before grant is legal, and that request is simply abandoned.

Optional Feature:
Macro TLB_ARB_PERF_CNT_EN.
- Defined: adds output ports hit_cnt[15:0] and miss_cnt[15:0].
  - Each counter increments once per response (either requester) by hit/fault outcome.
  - Both counters saturate at 16'hFFFF and reset to 0 with rst_n.
- Undefined: ports and counters are absent. Remaining behaviour is identical.

Test Plan:
- Single F request: entry 2 = {VPN 20'h00012, PFN 3'h5, valid 1, present 1}, f_vaddr=32'h00012ABC → f_gnt=1 same cycle; next cycle f_rsp_vld=1, f_PFN=5, f_page_fault=0.
- M write to read-only page: entry 4 = {VPN 20'h00040, PFN 3'h3, valid 1, present 1, writable 0}, m_vaddr=32'h00040010, m_wr=1 → m_rsp_vld=1 next cycle, m_PFN=3, m_page_fault=1. Repeat with m_wr=0 → m_page_fault=0.
- Miss: no matching VPN for f_vaddr=32'hDEAD0000 → f_PFN=0, f_page_fault=1. Clear present bit on a matching entry → fault=1.
- Starvation: f_req and m_req both held high → m_gnt for 3 consecutive cycles, f_gnt on the 4th, then m_gnt again; counter restarts from 0.
- Back-to-back: M requests on 4 consecutive cycles with distinct addresses → 4 consecutive m_rsp_vld pulses in order, each with the correct PFN.
- Reset mid-operation: assert rst_n=0 the cycle after a grant → no rsp_vld pulse; all outputs 0; the first request after release is granted normally.

Source files
------------

// File: rtl/tlb_lookup_arbiter.sv
// Two-port (fetch / mem) lookup arbiter in front of an 8-entry TLB: one lookup per cycle,
// M priority with fetch anti-starvation, registered response. Optional TLB_ARB_PERF_CNT_EN adds hit/miss counters.

module tlb_entry_cmp (
  input  logic [43:0] entry,
  input  logic [19:0] vpn,
  output logic        hit,
  output logic [2:0]  pfn,
  output logic        wbl
);
  logic unused_bits;
  assign unused_bits = ^{entry[23:7], entry[0]};

  assign hit = (entry[43:24] == vpn) & entry[3] & entry[2];
  assign pfn = entry[6:4];
  assign wbl = entry[1];
endmodule

module tlb_lookup_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [351:0] TLB,
  input  logic         f_req,
  input  logic [31:0]  f_vaddr,
  output logic         f_gnt,
  output logic         f_rsp_vld,
  output logic [2:0]   f_PFN,
  output logic         f_page_fault,
  input  logic         m_req,
  input  logic [31:0]  m_vaddr,
  input  logic         m_wr,
  output logic         m_gnt,
  output logic         m_rsp_vld,
  output logic [2:0]   m_PFN,
  output logic         m_page_fault
`ifdef TLB_ARB_PERF_CNT_EN
  ,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt
`endif
);
  localparam int NUM_ENT = 8;
  localparam int ENT_W   = 44;

  typedef struct packed {
    logic [31:0] vaddr;
    logic        wr;
  } lkup_req_t;

  typedef struct packed {
    logic [2:0] pfn;
    logic       fault;
  } lkup_rsp_t;

  logic [CNT_W-1:0] starve_cnt;
  logic             starved, f_win, m_win;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign f_win   = f_req & (~m_req | starved);
  assign m_win   = m_req & ~f_win;
  // Grants are masked by reset so nothing can be launched while held in reset.
  assign f_gnt   = f_win & rst_n;
  assign m_gnt   = m_win & rst_n;

  lkup_req_t req;
  always_comb begin
    req.vaddr = f_gnt ? f_vaddr : m_vaddr;
    req.wr    = m_gnt & m_wr;
  end

  logic unused_off;
  assign unused_off = ^req.vaddr[11:0];

  logic [NUM_ENT-1:0]      hit, wbl;
  logic [NUM_ENT-1:0][2:0] pfn;

  for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
    tlb_entry_cmp u_cmp (
      .entry (TLB[ENT_W*g +: ENT_W]),
      .vpn   (req.vaddr[31:12]),
      .hit   (hit[g]),
      .pfn   (pfn[g]),
      .wbl   (wbl[g])
    );
  end

  logic      single, sel_wbl;
  logic [2:0] sel_pfn;
  lkup_rsp_t rsp;

  // Multi-hit returns PFN 0 without faulting; write protection only applies to a unique hit.
  always_comb begin
    single  = (hit != '0) && ((hit & (hit - NUM_ENT'(1))) == '0);
    sel_pfn = '0;
    sel_wbl = 1'b0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (hit[i]) begin
        sel_pfn = sel_pfn | pfn[i];
        sel_wbl = sel_wbl | wbl[i];
      end
    end
    rsp.pfn   = single ? sel_pfn : 3'd0;
    rsp.fault = (hit == '0) | (single & req.wr & ~sel_wbl);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt   <= '0;
      f_rsp_vld    <= 1'b0;
      m_rsp_vld    <= 1'b0;
      f_PFN        <= '0;
      f_page_fault <= 1'b0;
      m_PFN        <= '0;
      m_page_fault <= 1'b0;
    end else begin
      f_rsp_vld <= f_gnt;
      m_rsp_vld <= m_gnt;
      if (f_gnt) {f_PFN, f_page_fault} <= rsp;
      if (m_gnt) {m_PFN, m_page_fault} <= rsp;
      if (!f_req || f_gnt)  starve_cnt <= '0;
      else if (!starved)    starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

`ifdef TLB_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (f_gnt | m_gnt) begin
      if (!rsp.fault && hit_cnt  != 16'hFFFF) hit_cnt  <= hit_cnt  + 16'd1;
      if (rsp.fault  && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Scoreboard bench for tlb_lookup_arbiter: directed scenarios then randomized traffic vs. a reference model.

module tb_tlb_lookup_arbiter;
  localparam int STARVE = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [351:0] tlb;
  logic         f_req, m_req, m_wr;
  logic [31:0]  f_vaddr, m_vaddr;
  logic         f_gnt, f_rsp_vld, f_page_fault;
  logic         m_gnt, m_rsp_vld, m_page_fault;
  logic [2:0]   f_PFN, m_PFN;
`ifdef TLB_ARB_PERF_CNT_EN
  logic [15:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  tlb_lookup_arbiter #(.STARVE_LIMIT(STARVE), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .TLB(tlb),
    .f_req(f_req), .f_vaddr(f_vaddr), .f_gnt(f_gnt), .f_rsp_vld(f_rsp_vld),
    .f_PFN(f_PFN), .f_page_fault(f_page_fault),
    .m_req(m_req), .m_vaddr(m_vaddr), .m_wr(m_wr), .m_gnt(m_gnt), .m_rsp_vld(m_rsp_vld),
    .m_PFN(m_PFN), .m_page_fault(m_page_fault)
`ifdef TLB_ARB_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  typedef struct {
    logic [2:0] pfn;
    logic       fault;
  } exp_t;

  exp_t f_q[$], m_q[$];
  exp_t last_f, last_m, e;
  int   n_cmp = 0, n_err = 0;
  int   model_cnt = 0, hit_m = 0, miss_m = 0;
  bit   f_was_gnt = 0, m_was_gnt = 0, efg, emg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference translation: count matching valid+present entries, then apply the fault rules.
  function automatic exp_t model(input logic [31:0] va, input bit is_m, input bit wr);
    exp_t r;
    int n;
    logic [2:0] p;
    bit w;
    n = 0; p = 0; w = 0;
    for (int i = 0; i < 8; i++) begin
      logic [43:0] ent;
      ent = tlb[44*i +: 44];
      if (ent[43:24] == va[31:12] && ent[3] && ent[2]) begin
        n++;
        p = ent[6:4];
        w = ent[1];
      end
    end
    r.pfn = 0; r.fault = 0;
    if (n == 0) r.fault = 1;
    else if (n == 1) begin
      r.pfn   = p;
      r.fault = is_m && wr && !w;
    end
    return r;
  endfunction

  task automatic set_entry(input int i, input logic [19:0] vpn, input logic [2:0] pfn,
                           input logic v, input logic p, input logic w);
    tlb[44*i +: 44] = {vpn, 17'h0, pfn, v, p, w, 1'b0};
  endtask

  function automatic logic [31:0] rand_va();
    logic [19:0] v;
    v = ($urandom_range(0, 7) == 0) ? 20'($urandom) : 20'h00010 + 20'($urandom_range(0, 11));
    return {v, 12'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: check responses from last cycle's grants, check arbitration, then queue new expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      f_q.delete(); m_q.delete();
      model_cnt = 0; hit_m = 0; miss_m = 0;
      last_f = '{pfn: 3'd0, fault: 1'b0};
      last_m = '{pfn: 3'd0, fault: 1'b0};
      chk("rst_f_rsp_vld", f_rsp_vld, 0);
      chk("rst_m_rsp_vld", m_rsp_vld, 0);
      chk("rst_f_pfn", f_PFN, 0);
      chk("rst_m_pfn", m_PFN, 0);
      chk("rst_f_fault", f_page_fault, 0);
      chk("rst_m_fault", m_page_fault, 0);
      chk("rst_f_gnt", f_gnt, 0);
      chk("rst_m_gnt", m_gnt, 0);
      f_was_gnt = 0; m_was_gnt = 0;
    end else begin
      chk("f_rsp_vld", f_rsp_vld, f_q.size() != 0);
      if (f_q.size() != 0) begin
        e = f_q.pop_front();
        if (f_rsp_vld) begin
          chk("f_pfn", f_PFN, e.pfn);
          chk("f_fault", f_page_fault, e.fault);
        end
        last_f = e;
      end else begin
        chk("f_pfn_hold", f_PFN, last_f.pfn);
        chk("f_fault_hold", f_page_fault, last_f.fault);
      end
      chk("m_rsp_vld", m_rsp_vld, m_q.size() != 0);
      if (m_q.size() != 0) begin
        e = m_q.pop_front();
        if (m_rsp_vld) begin
          chk("m_pfn", m_PFN, e.pfn);
          chk("m_fault", m_page_fault, e.fault);
        end
        last_m = e;
      end else begin
        chk("m_pfn_hold", m_PFN, last_m.pfn);
        chk("m_fault_hold", m_page_fault, last_m.fault);
      end
`ifdef TLB_ARB_PERF_CNT_EN
      chk("hit_cnt", hit_cnt, hit_m);
      chk("miss_cnt", miss_cnt, miss_m);
`endif
      efg = f_req && (!m_req || model_cnt == STARVE);
      emg = m_req && !efg;
      chk("f_gnt", f_gnt, efg);
      chk("m_gnt", m_gnt, emg);
      if (efg) begin
        e = model(f_vaddr, 0, 0);
        f_q.push_back(e);
      end
      if (emg) begin
        e = model(m_vaddr, 1, m_wr);
        m_q.push_back(e);
      end
      if (efg || emg) begin
        if (e.fault) miss_m = (miss_m < 16'hFFFF) ? miss_m + 1 : miss_m;
        else         hit_m  = (hit_m  < 16'hFFFF) ? hit_m  + 1 : hit_m;
      end
      model_cnt = (f_req && !efg) ? ((model_cnt < STARVE) ? model_cnt + 1 : STARVE) : 0;
      f_was_gnt = f_gnt;
      m_was_gnt = m_gnt;
    end
  end

  task automatic f_one(input logic [31:0] va);
    tick();
    f_vaddr = va; f_req = 1;
    tick();
    f_req = 0;
    @(negedge clk);
  endtask

  task automatic m_one(input logic [31:0] va, input logic wr);
    tick();
    m_vaddr = va; m_wr = wr; m_req = 1;
    tick();
    m_req = 0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [19:0] v;
    rst_n = 0; tlb = '0;
    f_req = 0; m_req = 0; m_wr = 0; f_vaddr = 0; m_vaddr = 0;
    repeat (3) tick();
    rst_n = 1;

    // single fetch hit
    tick();
    set_entry(2, 20'h00012, 3'h5, 1, 1, 1);
    f_vaddr = 32'h00012ABC; f_req = 1;
    @(negedge clk);
    chk("t1_f_gnt", f_gnt, 1);
    tick();
    f_req = 0;
    @(negedge clk);
    chk("t1_f_rsp_vld", f_rsp_vld, 1);
    chk("t1_f_pfn", f_PFN, 5);
    chk("t1_f_fault", f_page_fault, 0);

    // write to read-only page, then read
    set_entry(4, 20'h00040, 3'h3, 1, 1, 0);
    m_one(32'h00040010, 1);
    chk("t2_wr_vld", m_rsp_vld, 1);
    chk("t2_wr_pfn", m_PFN, 3);
    chk("t2_wr_fault", m_page_fault, 1);
    m_one(32'h00040010, 0);
    chk("t2_rd_pfn", m_PFN, 3);
    chk("t2_rd_fault", m_page_fault, 0);

    // misses
    f_one(32'hDEAD0000);
    chk("t3_miss_pfn", f_PFN, 0);
    chk("t3_miss_fault", f_page_fault, 1);
    set_entry(2, 20'h00012, 3'h5, 1, 0, 1);
    f_one(32'h00012ABC);
    chk("t3_np_pfn", f_PFN, 0);
    chk("t3_np_fault", f_page_fault, 1);

    // starvation: F wins every 4th cycle while both keep requesting
    tick();
    f_req = 1; m_req = 1; m_wr = 0;
    f_vaddr = 32'h00040000; m_vaddr = 32'h00040004;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t4_f_gnt", f_gnt, (c == 3 || c == 7));
      chk("t4_m_gnt", m_gnt, !(c == 3 || c == 7));
      tick();
      if (c == 3 || c == 7) f_vaddr = 32'h00012000;
      else m_vaddr = 32'hDEAD0000 + 32'(c);
    end
    f_req = 0; m_req = 0;

    // back-to-back M lookups
    for (int i = 0; i < 4; i++) set_entry(i, 20'h00100 + 20'(i), 3'(i + 1), 1, 1, 1);
    tick();
    m_req = 1; m_wr = 0; m_vaddr = 32'h00100000;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) begin
        v = 20'h00100 + 20'(i + 1);
        m_vaddr = {v, 12'h123};
      end else m_req = 0;
      @(negedge clk);
      chk("t5_vld", m_rsp_vld, 1);
      chk("t5_pfn", m_PFN, i + 1);
    end

    // reset right after a grant drops the lookup
    tick();
    f_vaddr = 32'h00100000; f_req = 1;
    @(negedge clk);
    chk("t6_gnt", f_gnt, 1);
    tick();
    f_req = 0; rst_n = 0;
    @(negedge clk);
    chk("t6_no_rsp", f_rsp_vld, 0);
    tick(); tick();
    rst_n = 1;
    @(negedge clk);
    chk("t6_post_rsp", f_rsp_vld, 0);
    f_one(32'h00101000);
    chk("t6_after_vld", f_rsp_vld, 1);
    chk("t6_after_pfn", f_PFN, 2);

    // randomized traffic with TLB churn and occasional resets
    for (int i = 0; i < 8; i++)
      set_entry(i, 20'h00010 + 20'($urandom_range(0, 11)), 3'($urandom),
                $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 15) == 0)
        set_entry($urandom_range(0, 7), 20'h00010 + 20'($urandom_range(0, 11)), 3'($urandom),
                  $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
      if (!f_req || f_was_gnt) begin
        f_req = ($urandom_range(0, 99) < 60);
        f_vaddr = rand_va();
      end else if ($urandom_range(0, 31) == 0) f_req = 0;
      if (!m_req || m_was_gnt) begin
        m_req = ($urandom_range(0, 99) < 70);
        m_vaddr = rand_va();
        m_wr = 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 31) == 0) m_req = 0;
    end
    tick();
    rst_n = 1; f_req = 0; m_req = 0;
    tick(); tick();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
